// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues word fetches over a valid/ready
// channel, buffers in-order responses and flushes everything on a redirect.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned FB_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        NextPCSrc,
  input  logic [31:0] ALURes,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_inst,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc4
);

  localparam int unsigned AW = $clog2(FB_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned OW = CW + 2;

  typedef logic [AW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  logic [31:0] pc_q, pc_d;
  cnt_t        out_cnt_q, out_cnt_d;
  cnt_t        disc_cnt_q, disc_cnt_d;
  cnt_t        fifo_cnt_q, fifo_cnt_d;
  ptr_t        fifo_wr_q, fifo_wr_d, fifo_rd_q, fifo_rd_d;
  ptr_t        ifl_wr_q, ifl_wr_d, ifl_rd_q, ifl_rd_d;

  logic [31:0] fifo_inst_q [FB_DEPTH];
  logic [31:0] fifo_pc_q   [FB_DEPTH];
  logic [31:0] ifl_pc_q    [FB_DEPTH];

  logic [OW-1:0] occ, occ_after_pop;
  logic          pop, accept, resp, resp_drop, resp_keep, resp_live;

  assign if_valid = (fifo_cnt_q != '0) & ~NextPCSrc & ~rst;
  assign pop      = if_valid & if_ready;

  // Discarded fetches still hold credit until their responses drain.
  assign occ            = OW'(out_cnt_q) + OW'(disc_cnt_q) + OW'(fifo_cnt_q);
  assign occ_after_pop  = occ - OW'(pop);
  assign imem_req_valid = ~rst & ~NextPCSrc & (occ_after_pop < OW'(FB_DEPTH));
  assign accept         = imem_req_valid & imem_req_ready;
  assign imem_addr      = rst ? RESET_PC : pc_q;

  assign resp      = imem_resp_valid & ~rst;
  assign resp_drop = resp & (disc_cnt_q != '0);
  assign resp_keep = resp & (disc_cnt_q == '0) & (out_cnt_q != '0);
  assign resp_live = resp_drop | resp_keep;

  assign if_inst = fifo_inst_q[fifo_rd_q];
  assign if_pc   = fifo_pc_q[fifo_rd_q];
  assign if_pc4  = if_pc + 32'd4;

  always_comb begin
    // NOTE: every next-state value gets its hold default first so no path
    // through the branches below can leave one unassigned and infer a latch.
    pc_d       = pc_q;
    out_cnt_d  = out_cnt_q;
    disc_cnt_d = disc_cnt_q;
    fifo_cnt_d = fifo_cnt_q;
    fifo_wr_d  = fifo_wr_q;
    fifo_rd_d  = fifo_rd_q;
    ifl_wr_d   = ifl_wr_q;
    ifl_rd_d   = ifl_rd_q;

    if (NextPCSrc) begin
      pc_d       = ALURes & 32'hFFFF_FFFE;
      disc_cnt_d = disc_cnt_q + out_cnt_q - cnt_t'(resp_live);
      out_cnt_d  = '0;
      fifo_cnt_d = '0;
      fifo_wr_d  = '0;
      fifo_rd_d  = '0;
      ifl_wr_d   = '0;
      ifl_rd_d   = '0;
    end else begin
      if (accept) pc_d = pc_q + 32'd4;
      out_cnt_d  = out_cnt_q + cnt_t'(accept) - cnt_t'(resp_keep);
      disc_cnt_d = disc_cnt_q - cnt_t'(resp_drop);
      fifo_cnt_d = fifo_cnt_q + cnt_t'(resp_keep) - cnt_t'(pop);
      fifo_wr_d  = fifo_wr_q + ptr_t'(resp_keep);
      fifo_rd_d  = fifo_rd_q + ptr_t'(pop);
      ifl_wr_d   = ifl_wr_q + ptr_t'(accept);
      ifl_rd_d   = ifl_rd_q + ptr_t'(resp_keep);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      out_cnt_q  <= '0;
      disc_cnt_q <= '0;
      fifo_cnt_q <= '0;
      fifo_wr_q  <= '0;
      fifo_rd_q  <= '0;
      ifl_wr_q   <= '0;
      ifl_rd_q   <= '0;
    end else begin
      pc_q       <= pc_d;
      out_cnt_q  <= out_cnt_d;
      disc_cnt_q <= disc_cnt_d;
      fifo_cnt_q <= fifo_cnt_d;
      fifo_wr_q  <= fifo_wr_d;
      fifo_rd_q  <= fifo_rd_d;
      ifl_wr_q   <= ifl_wr_d;
      ifl_rd_q   <= ifl_rd_d;
    end
  end

  // NOTE: storage arrays carry no reset; the counters gate every read, so the
  // array contents are never observed before being written.
  always_ff @(posedge clk) begin
    if (accept) ifl_pc_q[ifl_wr_q] <= pc_q;
    if (resp_keep) begin
      fifo_inst_q[fifo_wr_q] <= imem_resp_data;
      fifo_pc_q[fifo_wr_q]   <= ifl_pc_q[ifl_rd_q];
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a queue-based memory model plus an epoch-tagged
// reference of the decode stream, checked every cycle and per scenario.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] KEY      = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        NextPCSrc = 1'b0;
  logic [31:0] ALURes = '0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = '0;
  logic        if_valid;
  logic        if_ready = 1'b0;
  logic [31:0] if_inst, if_pc, if_pc4;

  fetch_unit #(.RESET_PC(RESET_PC), .FB_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .NextPCSrc(NextPCSrc), .ALURes(ALURes),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_addr(imem_addr), .imem_resp_valid(imem_resp_valid),
    .imem_resp_data(imem_resp_data), .if_valid(if_valid), .if_ready(if_ready),
    .if_inst(if_inst), .if_pc(if_pc), .if_pc4(if_pc4)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          due;
  } req_t;

  req_t        mem_q[$];   // accepted requests not yet answered (incl. stale)
  logic [31:0] mfifo[$];   // addresses the decode side should see, in order
  int          epoch = 0;
  int          cyc = 0;
  int          mem_lat = 1;
  int          n_tests = 0;
  int          n_fail = 0;
  int          n_pops = 0;
  logic [31:0] exp_addr = RESET_PC;

  // Memory: answers the oldest request once its latency has elapsed.
  initial forever begin
    @(posedge clk);
    cyc++;
    #1;
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = mem_q[0].addr ^ KEY;
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = $urandom;
    end
  end

  // Per-cycle reference check and model update, mid-cycle.
  bit   exp_ifv, exp_rv, pop_m, keep, acc;
  int   occ_m;
  req_t r;
  initial forever begin
    @(negedge clk);
    exp_ifv = !rst && !NextPCSrc && (mfifo.size() > 0);
    pop_m   = exp_ifv && if_ready;
    occ_m   = mem_q.size() + mfifo.size();
    exp_rv  = !rst && !NextPCSrc && (occ_m - int'(pop_m) < DEPTH);
    n_tests++;
    if (if_valid !== exp_ifv) begin
      n_fail++;
      $display("FAIL if_valid @%0d: got %b expected %b", cyc, if_valid, exp_ifv);
    end
    n_tests++;
    if (imem_req_valid !== exp_rv) begin
      n_fail++;
      $display("FAIL imem_req_valid @%0d: got %b expected %b", cyc, imem_req_valid, exp_rv);
    end
    n_tests++;
    if (imem_addr !== (rst ? RESET_PC : exp_addr)) begin
      n_fail++;
      $display("FAIL imem_addr @%0d: got %h expected %h", cyc, imem_addr, rst ? RESET_PC : exp_addr);
    end
    if (pop_m && if_valid === 1'b1) begin
      n_pops++;
      n_tests++;
      if (if_pc !== mfifo[0] || if_inst !== (mfifo[0] ^ KEY) || if_pc4 !== mfifo[0] + 32'd4) begin
        n_fail++;
        $display("FAIL if_data @%0d: got pc=%h inst=%h pc4=%h expected pc=%h inst=%h pc4=%h",
                 cyc, if_pc, if_inst, if_pc4, mfifo[0], mfifo[0] ^ KEY, mfifo[0] + 32'd4);
      end
    end
    if (rst) begin
      mem_q.delete();
      mfifo.delete();
      epoch++;
      exp_addr = RESET_PC;
    end else begin
      keep = 1'b0;
      if (imem_resp_valid && mem_q.size() > 0) begin
        r = mem_q.pop_front();
        keep = (r.epoch == epoch) && !NextPCSrc;
      end
      if (pop_m) mfifo.delete(0);
      acc = (imem_req_valid === 1'b1) && imem_req_ready;
      if (acc) mem_q.push_back('{imem_addr, epoch, cyc + mem_lat});
      if (NextPCSrc) begin
        mfifo.delete();
        epoch++;
        exp_addr = ALURes & 32'hFFFF_FFFE;
      end else begin
        if (keep) mfifo.push_back(r.addr);
        if (acc) exp_addr = exp_addr + 32'd4;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns at the start of the first cycle with rst low.
  task automatic apply_reset();
    tick();
    rst = 1'b1;
    NextPCSrc = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  // Collects n decode handshakes and checks them against a wrapping sequence.
  task automatic expect_seq(input logic [31:0] start, input int n, input string name);
    int got = 0;
    logic [31:0] exp;
    for (int c = 0; c < 40 && got < n; c++) begin
      @(negedge clk);
      if (if_valid === 1'b1 && if_ready) begin
        exp = start + 32'(4 * got);
        n_tests++;
        if (if_pc !== exp || if_pc4 !== exp + 32'd4) begin
          n_fail++;
          $display("FAIL %s pop %0d: got pc=%h pc4=%h expected pc=%h pc4=%h",
                   name, got, if_pc, if_pc4, exp, exp + 32'd4);
        end
        got++;
      end
      tick();
    end
    n_tests++;
    if (got != n) begin
      n_fail++;
      $display("FAIL %s count: got %0d pops expected %0d", name, got, n);
    end
  endtask

  task automatic test_reset();
    tick();
    rst = 1'b1;
    if_ready = 1'b0;
    imem_req_ready = 1'b1;
    @(negedge clk);
    n_tests++;
    if (imem_req_valid !== 1'b0 || if_valid !== 1'b0 || imem_addr !== RESET_PC) begin
      n_fail++;
      $display("FAIL reset_outputs: got req=%b ifv=%b addr=%h expected 0 0 %h",
               imem_req_valid, if_valid, imem_addr, RESET_PC);
    end
    tick();
    rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if (imem_req_valid !== 1'b1 || imem_addr !== RESET_PC) begin
      n_fail++;
      $display("FAIL first_request: got req=%b addr=%h expected 1 %h", imem_req_valid, imem_addr, RESET_PC);
    end
  endtask

  task automatic test_stream();
    mem_lat = 1;
    imem_req_ready = 1'b1;
    if_ready = 1'b1;
    apply_reset();
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      n_tests++;
      if (c < 2) begin
        if (if_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL stream_early c%0d: got if_valid=%b expected 0", c, if_valid);
        end
      end else if (if_valid !== 1'b1 || if_pc !== 32'(4 * (c - 2)) ||
                   if_pc4 !== 32'(4 * (c - 1)) || if_inst !== (32'(4 * (c - 2)) ^ KEY)) begin
        n_fail++;
        $display("FAIL stream c%0d: got v=%b pc=%h pc4=%h inst=%h expected pc=%h", c,
                 if_valid, if_pc, if_pc4, if_inst, 32'(4 * (c - 2)));
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    int n_acc = 0;
    mem_lat = 1;
    imem_req_ready = 1'b1;
    if_ready = 1'b0;
    apply_reset();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (imem_req_valid === 1'b1) n_acc++;
      if (c >= 2) begin
        n_tests++;
        if (if_valid !== 1'b1 || if_pc !== 32'h0) begin
          n_fail++;
          $display("FAIL bp_hold c%0d: got v=%b pc=%h expected 1 00000000", c, if_valid, if_pc);
        end
      end
      tick();
    end
    n_tests++;
    if (n_acc != DEPTH) begin
      n_fail++;
      $display("FAIL bp_requests: got %0d expected %0d", n_acc, DEPTH);
    end
    if_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_tests++;
      if (if_valid !== 1'b1 || if_pc !== 32'(4 * i)) begin
        n_fail++;
        $display("FAIL bp_release %0d: got v=%b pc=%h expected 1 %h", i, if_valid, if_pc, 32'(4 * i));
      end
      tick();
    end
  endtask

  task automatic test_redirect_stale();
    mem_lat = 3;
    imem_req_ready = 1'b1;
    if_ready = 1'b1;
    apply_reset();
    @(negedge clk);
    tick();
    @(negedge clk);
    tick();
    imem_req_ready = 1'b0;
    NextPCSrc = 1'b1;
    ALURes = 32'h0000_0101;
    @(negedge clk);
    n_tests++;
    if (if_valid !== 1'b0 || imem_req_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL redir_cycle: got ifv=%b req=%b expected 0 0", if_valid, imem_req_valid);
    end
    tick();
    NextPCSrc = 1'b0;
    imem_req_ready = 1'b1;
    @(negedge clk);
    n_tests++;
    if (imem_addr !== 32'h0000_0100 || imem_req_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL redir_addr: got addr=%h req=%b expected 00000100 1", imem_addr, imem_req_valid);
    end
    expect_seq(32'h0000_0100, 4, "redir_stale");
  endtask

  task automatic test_redirect_with_resp();
    mem_lat = 2;
    imem_req_ready = 1'b1;
    if_ready = 1'b1;
    apply_reset();
    repeat (6) tick();
    n_tests++;
    if (imem_resp_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL redir_resp_setup: got resp_valid=%b expected 1", imem_resp_valid);
    end
    NextPCSrc = 1'b1;
    ALURes = 32'h0000_0200;
    tick();
    NextPCSrc = 1'b0;
    expect_seq(32'h0000_0200, 8, "redir_resp");
  endtask

  task automatic test_wrap();
    mem_lat = 1;
    imem_req_ready = 1'b1;
    if_ready = 1'b1;
    apply_reset();
    NextPCSrc = 1'b1;
    ALURes = 32'hFFFF_FFFC;
    tick();
    NextPCSrc = 1'b0;
    expect_seq(32'hFFFF_FFFC, 3, "wrap");
  endtask

  task automatic test_reset_midstream();
    mem_lat = 3;
    imem_req_ready = 1'b1;
    if_ready = 1'b1;
    apply_reset();
    repeat (8) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_tests++;
      if (c == 0 && (imem_addr !== RESET_PC || imem_req_valid !== 1'b1)) begin
        n_fail++;
        $display("FAIL midrst_addr: got addr=%h req=%b expected %h 1", imem_addr, imem_req_valid, RESET_PC);
      end else if (c > 0 && c < 4 && if_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL midrst_quiet c%0d: got if_valid=%b expected 0", c, if_valid);
      end else if (c == 4 && (if_valid !== 1'b1 || if_pc !== RESET_PC)) begin
        n_fail++;
        $display("FAIL midrst_first: got v=%b pc=%h expected 1 %h", if_valid, if_pc, RESET_PC);
      end
      tick();
    end
  endtask

  task automatic test_random();
    int pops_before = n_pops;
    apply_reset();
    for (int i = 0; i < 3000; i++) begin
      imem_req_ready = ($urandom_range(3) != 0);
      if_ready       = ($urandom_range(9) < 7);
      mem_lat        = $urandom_range(4, 1);
      NextPCSrc      = ($urandom_range(19) == 0);
      ALURes         = $urandom;
      rst            = ($urandom_range(199) == 0);
      tick();
    end
    rst = 1'b0;
    NextPCSrc = 1'b0;
    tick();
    n_tests++;
    if (n_pops - pops_before < 300) begin
      n_fail++;
      $display("FAIL random_progress: got %0d pops expected at least 300", n_pops - pops_before);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_stale();
    test_redirect_with_resp();
    test_wrap();
    test_reset_midstream();
    test_random();
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
